dm_sync: RTL and testbench
==========================

Name: dm_sync

Overview:
- Synchronous, parametrised data memory for the pipelined MIPS32 core; MEM stage.
- Byte-addressed port with byte, halfword and word loads and stores, plus sign/zero extension on loads.
- Registered read with a valid flag.
- Self-clearing after reset via a sweep state machine; replaces the combinational word-only memory.

Parameters:
- DEPTH, 256, number of 32-bit words; power of two, >= 4.
- ADDR_W, 32, byte-address width.
- IDX_W, $clog2(DEPTH), word-index width (derived; not overridden).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous active-high reset.
- re  input  1  read request.
- we  input  1  write request.
- size  input  2  access size: 00 byte, 01 halfword, 10 word; 11 reserved, treated as no access.
- sign_ext  input  1  loads: 1 sign-extend, 0 zero-extend.
- addr  input  ADDR_W  byte address.
- wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- rdata  output  32  load result, extended.
- rvalid  output  1  rdata valid this cycle.
- ready  output  1  memory accepting requests.
- misalign  output  1  misaligned-access flag (see Optional Feature).

Behaviour:
- Word index = addr[IDX_W+1:2]; upper address bits are ignored, so addresses wrap modulo DEPTH*4.
- Byte lane = addr[1:0].

State machine, states CLEAR and RUN:
- rst=1 for an edge: state<=CLEAR, clear pointer<=0, ready<=0, rvalid<=0, rdata<=0, misalign<=0.
- CLEAR: each cycle writes 0 to mem[ptr] and increments ptr. After writing DEPTH-1, goes to RUN the next edge with ready<=1.
- Clearing takes exactly DEPTH cycles after rst deasserts.
- rst asserted during CLEAR restarts the sweep at 0. rst during RUN returns to CLEAR; memory contents are lost.
- re and we are ignored while ready=0; no memory change, and rvalid stays 0.

Accepting requests in RUN:
- A request is accepted when ready=1, (re|we)=1, size!=11 and the access is not misaligned.

Store (we), commits at the edge:
- Byte: writes wdata[7:0] to lane addr[1:0] only.
- Half: writes wdata[15:0] to lanes {addr[1],0} and {addr[1],1}.
- Word: writes all four lanes.
- Untouched lanes keep their value.
- Little-endian: lane 0 = bits [7:0].

Load (re):
- 1-cycle latency. At the accepting edge, rdata<=extracted and extended value and rvalid<=1.
- Otherwise rvalid<=0 and rdata holds its last value.
- Byte: lane addr[1:0]. Half: lanes selected by addr[1]. Extension per sign_ext; sign_ext is ignored for word.

Simultaneous and boundary cases:
- re and we on the same edge: read-first. The load returns pre-write data, even for the same word; the store still commits.
- size=11: no write, rvalid<=0, misalign unaffected.
- Back-to-back loads: one result per cycle, no bubbles.

Optional Feature:
- Macro DM_ALIGN_CHECK_EN.
- Defined:
  - A half access with addr[0]=1, or a word access with addr[1:0]!=0, is misaligned.
  - On a misaligned request: no write, rvalid<=0, misalign<=1 for exactly one cycle (registered, aligned with where rvalid would be). Otherwise misalign<=0.
- Not defined:
  - misalign is tied to 0.
  - Offending low bits are masked: half uses addr[1], word uses lane 0.
  - The access proceeds normally.

Test Plan:
- Reset/clear: DEPTH=8, write patterns, pulse rst -> ready=0 for 8 cycles then 1; every word reads 0x00000000 with rvalid one cycle after re; re during CLEAR -> rvalid stays 0.
- Word RW and latency: sw 0xDEADBEEF @0x10, then lw @0x10 -> next cycle rdata=0xDEADBEEF, rvalid=1; back-to-back lw @0x10, @0x14 -> consecutive rvalid cycles.
- Byte/half merge: sw 0x11223344 @0x20, sb 0xAA @0x21, sh 0x8001 @0x22 -> lw =0x8001AA44; lb @0x21 sign_ext=1 -> 0xFFFFFFAA; lbu -> 0x000000AA; lh @0x22 -> 0xFFFF8001.
- Read-during-write: word @0x30 =0x1, same edge re+we wdata=0x2 @0x30 -> rdata=0x1; next lw -> 0x2.
- Wrap: DEPTH=8, sw 0x55 @0x00, lw @0x20 -> 0x00000055.
- Misalign (DM_ALIGN_CHECK_EN): sw 0xFFFFFFFF @0x42 -> misalign=1 one cycle, lw @0x40 unchanged; without macro the same sh @0x43 writes lanes 2–3.

Source files
------------

// File: rtl/dm_sync.sv
// Byte-addressed synchronous data memory for the MIPS32 MEM stage. It supports
// byte, halfword and word access, extends loads and self-clears after reset.
// Define DM_ALIGN_CHECK_EN to reject misaligned half/word accesses and flag them on misalign.
module dm_sync #(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              re,
    input  logic              we,
    input  logic [1:0]        size,
    input  logic              sign_ext,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              rvalid,
    output logic              ready,
    output logic              misalign
);
    localparam int IDX_W = $clog2(DEPTH);

    // Handshake: a request (re|we) is taken on a rising edge only while ready=1.
    // A load result appears one cycle later, qualified by a one-cycle rvalid pulse.
    typedef enum logic {CLEAR, RUN} state_t;

    state_t           state, state_next;
    logic [IDX_W-1:0] ptr, ptr_next;
    logic [31:0]      mem [DEPTH];

    logic [IDX_W-1:0] idx;
    logic [1:0]       lane;
    logic [3:0]       be;
    logic [31:0]      wd_al;
    logic [31:0]      word;
    logic [31:0]      shifted;
    logic [31:0]      ld;
    logic             mis;
    logic             valid_size;
    logic             accept;
    logic             unused_addr;

    assign idx         = addr[IDX_W+1:2];
    assign unused_addr = ^addr[ADDR_W-1:IDX_W+2];
    assign ready       = (state == RUN);
    assign valid_size  = (size != 2'b11);
    assign accept      = ready && (re || we) && valid_size && !mis;

    always_comb begin
        state_next = state;
        ptr_next   = ptr;
        case (state)
            CLEAR: begin
                ptr_next = ptr + 1'b1;
                if (ptr == IDX_W'(DEPTH - 1)) state_next = RUN;
            end
            default: state_next = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= CLEAR;
            ptr   <= '0;
        end else begin
            state <= state_next;
            ptr   <= ptr_next;
        end
    end

    // Lane selection; without the alignment check the offending low bits are simply masked.
    always_comb begin
        lane  = 2'b00;
        be    = 4'b0000;
        wd_al = wdata;
        mis   = 1'b0;
        case (size)
            2'b00: begin
                lane  = addr[1:0];
                be    = 4'b0001 << addr[1:0];
                wd_al = {4{wdata[7:0]}};
            end
            2'b01: begin
                lane  = {addr[1], 1'b0};
                be    = addr[1] ? 4'b1100 : 4'b0011;
                wd_al = {2{wdata[15:0]}};
`ifdef DM_ALIGN_CHECK_EN
                mis   = addr[0];
`endif
            end
            2'b10: begin
                be    = 4'b1111;
`ifdef DM_ALIGN_CHECK_EN
                mis   = (addr[1:0] != 2'b00);
`endif
            end
            default: be = 4'b0000;
        endcase
    end

    assign word    = mem[idx];
    assign shifted = word >> {lane, 3'b000};

    always_comb begin
        ld = word;
        case (size)
            2'b00:   ld = {{24{sign_ext & shifted[7]}}, shifted[7:0]};
            2'b01:   ld = {{16{sign_ext & shifted[15]}}, shifted[15:0]};
            default: ld = word;
        endcase
    end

    // Reading mem before the non-blocking store lands gives read-first behaviour.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == CLEAR) begin
                mem[ptr] <= '0;
            end else if (accept && we) begin
                for (int i = 0; i < 4; i++) begin
                    if (be[i]) mem[idx][8*i +: 8] <= wd_al[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rvalid <= 1'b0;
            rdata  <= '0;
        end else begin
            rvalid <= accept && re;
            if (accept && re) rdata <= ld;
        end
    end

`ifdef DM_ALIGN_CHECK_EN
    always_ff @(posedge clk) begin
        if (rst) misalign <= 1'b0;
        else     misalign <= ready && (re || we) && valid_size && mis;
    end
`else
    assign misalign = 1'b0;
`endif

endmodule

// File: tb/tb_dm_sync.sv
// Directed testbench for dm_sync (DEPTH=8). It covers clear timing, word/byte/half
// access, extension, read-first, wrap, reserved size and alignment handling.
module tb_dm_sync;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        re;
    logic        we;
    logic [1:0]  size;
    logic        sign_ext;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        rvalid;
    logic        ready;
    logic        misalign;

    int n_total = 0;
    int n_pass  = 0;
    logic [31:0] exp_q[$];

    dm_sync #(.DEPTH(DEPTH), .ADDR_W(32)) dut (
        .clk(clk), .rst(rst), .re(re), .we(we), .size(size),
        .sign_ext(sign_ext), .addr(addr), .wdata(wdata),
        .rdata(rdata), .rvalid(rvalid), .ready(ready), .misalign(misalign)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic req(input logic r, input logic w, input logic [1:0] sz, input logic sx,
                       input logic [31:0] a, input logic [31:0] d);
        re = r; we = w; size = sz; sign_ext = sx; addr = a; wdata = d;
        cyc();
        re = 1'b0; we = 1'b0;
    endtask

    task automatic store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
        req(1'b0, 1'b1, sz, 1'b0, a, d);
    endtask

    task automatic load(input string tag, input logic [1:0] sz, input logic sx,
                        input logic [31:0] a, input logic [31:0] exp);
        exp_q.push_back(exp);
        req(1'b1, 1'b0, sz, sx, a, 32'h0);
        check({tag, "_rvalid"}, {31'b0, rvalid}, 32'h1);
        check(tag, rdata, exp_q.pop_front());
    endtask

    // Drive rst low, then expect ready low for DEPTH cycles with loads ignored.
    task automatic clear_seq(input string tag);
        logic bad;
        bad = 1'b0;
        rst = 1'b0;
        re = 1'b1; size = 2'b10; addr = 32'h0;
        for (int i = 0; i < DEPTH; i++) begin
            if (i == DEPTH - 1) re = 1'b0;
            cyc();
            if (i < DEPTH - 1 && (ready || rvalid)) bad = 1'b1;
        end
        check({tag, "_busy"}, {31'b0, bad}, 32'h0);
        check({tag, "_ready"}, {31'b0, ready}, 32'h1);
        check({tag, "_rvalid"}, {31'b0, rvalid}, 32'h0);
    endtask

    initial begin
        rst = 1'b1; re = 1'b0; we = 1'b0; size = 2'b10; sign_ext = 1'b0;
        addr = 32'h0; wdata = 32'h0;
        cyc(); cyc();
        check("rst_ready", {31'b0, ready}, 32'h0);
        check("rst_rvalid", {31'b0, rvalid}, 32'h0);
        check("rst_rdata", rdata, 32'h0);
        check("rst_misalign", {31'b0, misalign}, 32'h0);
        clear_seq("clr0");

        for (int i = 0; i < DEPTH; i++) store(2'b10, 32'(i * 4), 32'hA500_0000 | 32'(i));
        load("pattern3", 2'b10, 1'b0, 32'h0C, 32'hA500_0003);

        rst = 1'b1;
        cyc();
        check("rerst_ready", {31'b0, ready}, 32'h0);
        check("rerst_rdata", rdata, 32'h0);
        clear_seq("clr1");
        for (int i = 0; i < DEPTH; i++) load($sformatf("zero%0d", i), 2'b10, 1'b0, 32'(i * 4), 32'h0);

        store(2'b10, 32'h10, 32'hDEAD_BEEF);
        load("lw_10", 2'b10, 1'b1, 32'h10, 32'hDEAD_BEEF);
        store(2'b10, 32'h14, 32'h1234_5678);
        re = 1'b1; size = 2'b10; sign_ext = 1'b0; addr = 32'h10;
        cyc();
        check("b2b0_rvalid", {31'b0, rvalid}, 32'h1);
        check("b2b0", rdata, 32'hDEAD_BEEF);
        addr = 32'h14;
        cyc();
        re = 1'b0;
        check("b2b1_rvalid", {31'b0, rvalid}, 32'h1);
        check("b2b1", rdata, 32'h1234_5678);
        cyc();
        check("idle_rvalid", {31'b0, rvalid}, 32'h0);
        check("idle_hold", rdata, 32'h1234_5678);

        store(2'b10, 32'h20, 32'h1122_3344);
        store(2'b00, 32'h21, 32'h0000_00AA);
        store(2'b01, 32'h22, 32'h0000_8001);
        load("merge_lw", 2'b10, 1'b0, 32'h20, 32'h8001_AA44);
        load("lb_21", 2'b00, 1'b1, 32'h21, 32'hFFFF_FFAA);
        load("lbu_21", 2'b00, 1'b0, 32'h21, 32'h0000_00AA);
        load("lb_20", 2'b00, 1'b1, 32'h20, 32'h0000_0044);
        load("lh_22", 2'b01, 1'b1, 32'h22, 32'hFFFF_8001);
        load("lhu_22", 2'b01, 1'b0, 32'h22, 32'h0000_8001);
        load("lh_20", 2'b01, 1'b1, 32'h20, 32'hFFFF_AA44);

        store(2'b10, 32'h30, 32'h0000_0001);
        exp_q.push_back(32'h0000_0001);
        req(1'b1, 1'b1, 2'b10, 1'b0, 32'h30, 32'h0000_0002);
        check("rdw_rvalid", {31'b0, rvalid}, 32'h1);
        check("rdw_old", rdata, exp_q.pop_front());
        load("rdw_new", 2'b10, 1'b0, 32'h30, 32'h0000_0002);

        store(2'b10, 32'h00, 32'h0000_0055);
        load("wrap", 2'b10, 1'b0, 32'h20, 32'h0000_0055);

        req(1'b1, 1'b1, 2'b11, 1'b1, 32'h00, 32'hFFFF_FFFF);
        check("sz11_rvalid", {31'b0, rvalid}, 32'h0);
        check("sz11_misalign", {31'b0, misalign}, 32'h0);
        load("sz11_nowrite", 2'b10, 1'b0, 32'h00, 32'h0000_0055);

`ifdef DM_ALIGN_CHECK_EN
        store(2'b10, 32'h42, 32'hFFFF_FFFF);
        check("mis_flag", {31'b0, misalign}, 32'h1);
        check("mis_rvalid", {31'b0, rvalid}, 32'h0);
        cyc();
        check("mis_clear", {31'b0, misalign}, 32'h0);
        req(1'b1, 1'b0, 2'b01, 1'b0, 32'h41, 32'h0);
        check("mis_lh_flag", {31'b0, misalign}, 32'h1);
        check("mis_lh_rvalid", {31'b0, rvalid}, 32'h0);
        load("mis_nowrite", 2'b10, 1'b0, 32'h40, 32'h0000_0055);
`else
        store(2'b01, 32'h43, 32'h0000_BEEF);
        check("nomis_flag", {31'b0, misalign}, 32'h0);
        load("nomis_sh", 2'b10, 1'b0, 32'h40, 32'hBEEF_0055);
        load("nomis_lh", 2'b01, 1'b0, 32'h41, 32'h0000_0055);
        load("nomis_lw", 2'b10, 1'b0, 32'h43, 32'hBEEF_0055);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
